// File: rtl/dcache_access_arbiter.sv
// Arbitrates the dcache access slot between CPU ports (round-robin) and ACE snoops (priority, streak-limited).
// Grants are combinational in IDLE; a CPU grant is followed by a one-cycle tag phase and an optional controller lock.
module dcache_access_arbiter #(
  parameter int NR_CPU_PORTS     = 3,
  parameter int SNOOP_STREAK_MAX = 4,
  localparam int SrcW            = $clog2(NR_CPU_PORTS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NR_CPU_PORTS-1:0] cpu_req_i,
  output logic [NR_CPU_PORTS-1:0] cpu_gnt_o,
  input  logic                    snoop_valid_i,
  output logic                    snoop_ready_o,
  output logic                    acc_req_o,
  output logic [SrcW-1:0]         acc_src_o,
  input  logic                    acc_gnt_i,
  input  logic                    acc_lock_i,
  output logic                    owner_valid_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CPU_TAG = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [SrcW-1:0] SnoopSrc  = SrcW'(NR_CPU_PORTS);
  localparam logic [SrcW-1:0] LastPort  = SrcW'(NR_CPU_PORTS - 1);
  localparam logic [3:0]      StreakMax = 4'(SNOOP_STREAK_MAX);

  logic [1:0]      r_state;
  logic [SrcW-1:0] r_rr_ptr;
  logic [SrcW-1:0] r_owner;
  logic [3:0]      r_streak;

  logic            w_idle;
  logic            w_any_cpu;
  logic            w_snoop_win;
  logic            w_cpu_vld;
  logic [SrcW-1:0] w_cpu_idx;
  logic            w_cand_vld;
  logic [SrcW-1:0] w_cand_src;
  logic            w_grant;
  int              w_p;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_any_cpu   = |cpu_req_i;
  assign w_snoop_win = snoop_valid_i & ((r_streak < StreakMax) | ~w_any_cpu);

  // Walk from the highest offset down so the port closest to r_rr_ptr is written last and wins.
  always_comb begin
    w_cpu_vld = 1'b0;
    w_cpu_idx = '0;
    w_p       = 0;
    for (int k = NR_CPU_PORTS - 1; k >= 0; k--) begin
      w_p = (int'(r_rr_ptr) + k) % NR_CPU_PORTS;
      if ((cpu_req_i & (NR_CPU_PORTS'(1) << w_p)) != '0) begin
        w_cpu_vld = 1'b1;
        w_cpu_idx = SrcW'(w_p);
      end
    end
  end

  assign w_cand_vld = w_snoop_win | w_cpu_vld;
  assign w_cand_src = w_snoop_win ? SnoopSrc : w_cpu_idx;
  assign w_grant    = acc_req_o & acc_gnt_i;

  // Outputs are forced low while reset is held, including the combinational IDLE request path.
  assign acc_req_o     = ~rst_i & w_idle & w_cand_vld;
  assign acc_src_o     = rst_i ? '0 : (w_idle ? (w_cand_vld ? w_cand_src : '0) : r_owner);
  assign snoop_ready_o = w_grant & w_snoop_win;
  assign cpu_gnt_o     = (w_grant & ~w_snoop_win) ? (NR_CPU_PORTS'(1) << w_cpu_idx) : '0;
  assign owner_valid_o = ~rst_i & ~w_idle;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_streak <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant && w_snoop_win) begin
            r_state  <= acc_lock_i ? ST_LOCKED : ST_IDLE;
            r_owner  <= SnoopSrc;
            r_streak <= !w_any_cpu ? 4'd0 :
                        (r_streak == StreakMax) ? r_streak : r_streak + 4'd1;
          end else if (w_grant) begin
            r_state  <= ST_CPU_TAG;
            r_owner  <= w_cpu_idx;
            r_rr_ptr <= (w_cpu_idx == LastPort) ? '0 : w_cpu_idx + SrcW'(1);
            r_streak <= 4'd0;
          end else if (!w_any_cpu) begin
            r_streak <= 4'd0;
          end
        end
        // Tag and locked phases both leave on the first cycle the lock is sampled low.
        default: r_state <= acc_lock_i ? ST_LOCKED : ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_access_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a behavioural arbiter model.
module tb_dcache_access_arbiter;
  localparam int N   = 3;
  localparam int MAX = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] cpu_req_i;
  logic [N-1:0] cpu_gnt_o;
  logic         snoop_valid_i;
  logic         snoop_ready_o;
  logic         acc_req_o;
  logic [1:0]   acc_src_o;
  logic         acc_gnt_i;
  logic         acc_lock_i;
  logic         owner_valid_o;

  int n_chk  = 0;
  int n_fail = 0;

  dcache_access_arbiter #(.NR_CPU_PORTS(N), .SNOOP_STREAK_MAX(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_gnt_o(cpu_gnt_o),
    .snoop_valid_i(snoop_valid_i), .snoop_ready_o(snoop_ready_o),
    .acc_req_o(acc_req_o), .acc_src_o(acc_src_o),
    .acc_gnt_i(acc_gnt_i), .acc_lock_i(acc_lock_i),
    .owner_valid_o(owner_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {cpu_gnt_o, snoop_ready_o, acc_req_o, acc_src_o, owner_valid_o};
  endfunction

  // Called just after a rising edge: drive, check at the falling edge, step to after the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] req, input logic snp, input logic gnt,
                     input logic lock, input logic [2:0] e_gnt, input logic e_rdy,
                     input logic e_req, input logic [1:0] e_src, input logic e_ov);
    cpu_req_i = req; snoop_valid_i = snp; acc_gnt_i = gnt; acc_lock_i = lock;
    @(negedge clk_i);
    chk(tag, {24'd0, outs()}, {24'd0, e_gnt, e_rdy, e_req, e_src, e_ov});
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cpu_req_i = '0; snoop_valid_i = 1'b0; acc_gnt_i = 1'b0; acc_lock_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Behavioural model state: phase 0 idle, 1 tag, 2 locked
  int m_st, m_rr, m_stk, m_own;
  logic [2:0] tb_req;
  logic       tb_snp;

  initial begin
    rst_i = 1'b1;
    cpu_req_i = 3'b111; snoop_valid_i = 1'b1; acc_gnt_i = 1'b1; acc_lock_i = 1'b1;
    #2 chk("reset_outs", {24'd0, outs()}, 32'd0);
    do_reset();

    cyc("single_gnt", 3'b010, 0, 1, 0, 3'b010, 0, 1, 2'd1, 0);
    cyc("single_tag", 3'b000, 0, 1, 0, 3'b000, 0, 0, 2'd1, 1);
    cyc("single_idle", 3'b000, 0, 1, 0, 3'b000, 0, 0, 2'd0, 0);
    cyc("single_rr2", 3'b011, 0, 1, 0, 3'b001, 0, 1, 2'd0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc("rr_gnt", 3'b111, 0, 1, 0, 3'(1 << (i % 3)), 0, 1, 2'(i % 3), 0);
      cyc("rr_tag", 3'b111, 0, 1, 0, 3'b000, 0, 0, 2'(i % 3), 1);
    end

    do_reset();
    for (int i = 0; i < 4; i++) cyc("streak_snp", 3'b001, 1, 1, 0, 3'b000, 1, 1, 2'd3, 0);
    cyc("streak_cpu", 3'b001, 1, 1, 0, 3'b001, 0, 1, 2'd0, 0);
    cyc("streak_tag", 3'b001, 1, 1, 0, 3'b000, 0, 0, 2'd0, 1);
    cyc("streak_again", 3'b001, 1, 1, 0, 3'b000, 1, 1, 2'd3, 0);

    do_reset();
    cyc("lock_gnt", 3'b000, 1, 1, 1, 3'b000, 1, 1, 2'd3, 0);
    for (int i = 0; i < 4; i++) cyc("lock_hold", 3'b010, 1, 1, 1, 3'b000, 0, 0, 2'd3, 1);
    cyc("lock_fall", 3'b010, 1, 1, 0, 3'b000, 0, 0, 2'd3, 1);
    cyc("lock_free", 3'b010, 1, 1, 0, 3'b000, 1, 1, 2'd3, 0);

    do_reset();
    for (int i = 0; i < 3; i++) cyc("bp_hold", 3'b100, 0, 0, 0, 3'b000, 0, 1, 2'd2, 0);
    cyc("bp_gnt", 3'b100, 0, 1, 0, 3'b100, 0, 1, 2'd2, 0);

    do_reset();
    cyc("rl_gnt", 3'b000, 1, 1, 1, 3'b000, 1, 1, 2'd3, 0);
    cyc("rl_locked", 3'b001, 1, 1, 1, 3'b000, 0, 0, 2'd3, 1);
    @(negedge clk_i); #1 rst_i = 1'b1;
    #1 chk("rst_in_lock", {24'd0, outs()}, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    cyc("rl_after", 3'b001, 0, 1, 0, 3'b001, 0, 1, 2'd0, 0);

    do_reset();
    m_st = 0; m_rr = 0; m_stk = 0; m_own = 0;
    tb_req = '0; tb_snp = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic       any, grant, lock;
      int         cand;
      logic [2:0] e_gnt;
      logic       e_rdy, e_req, e_ov;
      logic [1:0] e_src;
      cpu_req_i     = tb_req;
      snoop_valid_i = tb_snp;
      acc_gnt_i     = ($urandom_range(0, 3) != 0);
      acc_lock_i    = ($urandom_range(0, 3) == 0);
      lock = acc_lock_i;
      @(negedge clk_i);
      any = |tb_req;
      e_gnt = '0; e_rdy = 1'b0; e_req = 1'b0; e_src = '0; e_ov = 1'b0;
      if (m_st == 0) begin
        cand = -1;
        if (tb_snp && (m_stk < MAX || !any)) cand = N;
        else
          for (int k = 0; k < N; k++)
            if (cand < 0 && (((tb_req >> ((m_rr + k) % N)) & 3'b001) != 3'b000))
              cand = (m_rr + k) % N;
        grant = (cand >= 0) && acc_gnt_i;
        if (cand >= 0) begin e_req = 1'b1; e_src = 2'(cand); end
        if (grant && cand == N) begin
          e_rdy = 1'b1;
          m_st  = lock ? 2 : 0;
          m_own = N;
          m_stk = any ? ((m_stk < MAX) ? m_stk + 1 : MAX) : 0;
        end else if (grant) begin
          e_gnt = 3'(1 << cand);
          m_st  = 1;
          m_own = cand;
          m_rr  = (cand + 1) % N;
          m_stk = 0;
        end else if (!any) begin
          m_stk = 0;
        end
      end else begin
        e_src = 2'(m_own);
        e_ov  = 1'b1;
        m_st  = lock ? 2 : 0;
      end
      chk("rnd_cpu_gnt", {29'd0, cpu_gnt_o}, {29'd0, e_gnt});
      chk("rnd_snoop_rdy", {31'd0, snoop_ready_o}, {31'd0, e_rdy});
      chk("rnd_acc_req", {31'd0, acc_req_o}, {31'd0, e_req});
      chk("rnd_acc_src", {30'd0, acc_src_o}, {30'd0, e_src});
      chk("rnd_owner_vld", {31'd0, owner_valid_o}, {31'd0, e_ov});

      tb_req = (tb_req & ~e_gnt) | (3'($urandom) & 3'($urandom));
      if ($urandom_range(0, 19) == 0) tb_req = tb_req & 3'($urandom);
      if (e_rdy) tb_snp = ($urandom_range(0, 3) != 0);
      else if (!tb_snp) tb_snp = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 19) == 0) tb_snp = 1'b0;

      if ($urandom_range(0, 199) == 0) begin
        #1 rst_i = 1'b1;
        #1 chk("rnd_rst_outs", {24'd0, outs()}, 32'd0);
        m_st = 0; m_rr = 0; m_stk = 0; m_own = 0;
        @(posedge clk_i); #1 rst_i = 1'b0;
      end else begin
        @(posedge clk_i); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
